// File: rtl/bcd_clock_pkg.sv
// Shared types and limits for the BCD clock set/run controller.
// State encoding doubles as the mode output for RUN and the set states.
package bcd_clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ms;
    bcd_t ls;
  } bcd2_t;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  localparam logic [7:0] HR_LIMIT = 8'h23;
  localparam logic [7:0] MS_LIMIT = 8'h59;

endpackage

// File: rtl/bcd_clock_ctrl_if.sv
// Bundle between the controller, its buttons and the BCD time counter.
// master = controller side, slave = counter/button side.
interface bcd_clock_ctrl_if;
  import bcd_clock_pkg::*;

  logic       btn_mode;
  logic       btn_inc;

  bcd_t       cur_ms_hr;
  bcd_t       cur_ls_hr;
  bcd_t       cur_ms_min;
  bcd_t       cur_ls_min;
  bcd_t       cur_ms_sec;
  bcd_t       cur_ls_sec;

  logic       tick_en;
  logic       load;

  bcd_t       ld_ms_hr;
  bcd_t       ld_ls_hr;
  bcd_t       ld_ms_min;
  bcd_t       ld_ls_min;
  bcd_t       ld_ms_sec;
  bcd_t       ld_ls_sec;

  logic [1:0] mode;

  modport master (
    input  btn_mode,
    input  btn_inc,
    input  cur_ms_hr,
    input  cur_ls_hr,
    input  cur_ms_min,
    input  cur_ls_min,
    input  cur_ms_sec,
    input  cur_ls_sec,
    output tick_en,
    output load,
    output ld_ms_hr,
    output ld_ls_hr,
    output ld_ms_min,
    output ld_ls_min,
    output ld_ms_sec,
    output ld_ls_sec,
    output mode
  );

  modport slave (
    output btn_mode,
    output btn_inc,
    output cur_ms_hr,
    output cur_ls_hr,
    output cur_ms_min,
    output cur_ls_min,
    output cur_ms_sec,
    output cur_ls_sec,
    input  tick_en,
    input  load,
    input  ld_ms_hr,
    input  ld_ls_hr,
    input  ld_ms_min,
    input  ld_ls_min,
    input  ld_ms_sec,
    input  ld_ls_sec,
    input  mode
  );

endinterface

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD incrementer: wraps to 00 when the value is at or
// above the limit, so out-of-range captures recover on one press.
module bcd_wrap_inc
  import bcd_clock_pkg::*;
(
  input  bcd2_t val,
  input  bcd2_t limit,
  output bcd2_t nxt
);

  always_comb begin
    nxt = '0;
    if (val >= limit) begin
      nxt = '0;
    end else if (val.ls >= 4'd9) begin
      nxt.ms = val.ms + 4'd1;
      nxt.ls = 4'd0;
    end else begin
      nxt.ms = val.ms;
      nxt.ls = val.ls + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_clock_ctrl.sv
// Run/set controller for a BCD clock: one-second prescaler in RUN,
// shadow-register editing in the set states, one-cycle load on COMMIT.
module bcd_clock_ctrl
  import bcd_clock_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  bcd_clock_ctrl_if.master bus
);

  localparam int PW =
    (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;

  logic          mode_q;
  logic          inc_q;
  logic          mode_press;
  logic          inc_press;

  bcd2_t         sh_hr;
  bcd2_t         sh_min;
  bcd2_t         sh_sec;
  bcd2_t         inc_in;
  bcd2_t         inc_lim;
  bcd2_t         inc_out;

  bcd2_t         cap_hr;
  bcd2_t         cap_min;
  bcd2_t         cap_sec;

  logic          capture;
  logic          bump;
  logic          commit;

  assign mode_press = bus.btn_mode & ~mode_q;
  assign inc_press  = bus.btn_inc & ~inc_q;

  assign cap_hr  = {bus.cur_ms_hr, bus.cur_ls_hr};
  assign cap_min = {bus.cur_ms_min, bus.cur_ls_min};
  assign cap_sec = {bus.cur_ms_sec, bus.cur_ls_sec};

  // Mode press wins over a simultaneous inc press.
  assign capture = (state == RUN) & mode_press;
  assign bump    = inc_press & ~mode_press;

  always_comb begin
    inc_in  = sh_hr;
    inc_lim = HR_LIMIT;
    case (state)
      SET_MIN: begin
        inc_in  = sh_min;
        inc_lim = MS_LIMIT;
      end
      SET_SEC: begin
        inc_in  = sh_sec;
        inc_lim = MS_LIMIT;
      end
      default: begin
        inc_in  = sh_hr;
        inc_lim = HR_LIMIT;
      end
    endcase
  end

  bcd_wrap_inc u_inc (
    .val   (inc_in),
    .limit (inc_lim),
    .nxt   (inc_out)
  );

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_nxt = SET_HR;
        end else if (presc == PMAX) begin
          presc_nxt = '0;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      SET_HR: begin
        if (mode_press) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (mode_press) state_nxt = SET_SEC;
      end
      SET_SEC: begin
        if (mode_press) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      presc  <= '0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      mode_q <= bus.btn_mode;
      inc_q  <= bus.btn_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_hr  <= '0;
      sh_min <= '0;
      sh_sec <= '0;
    end else if (capture) begin
      sh_hr  <= cap_hr;
      sh_min <= cap_min;
      sh_sec <= cap_sec;
    end else if (bump) begin
      case (state)
        SET_HR:  sh_hr  <= inc_out;
        SET_MIN: sh_min <= inc_out;
        SET_SEC: sh_sec <= inc_out;
        default: ;
      endcase
    end
  end

  assign commit = (state == COMMIT);

  assign bus.tick_en = (state == RUN) &
                       (presc == PMAX);
  assign bus.load    = commit;

  // COMMIT keeps showing the SET_SEC code.
  assign bus.mode = commit ? 2'd3 : state[1:0];

  assign bus.ld_ms_hr  = commit ? sh_hr.ms  : '0;
  assign bus.ld_ls_hr  = commit ? sh_hr.ls  : '0;
  assign bus.ld_ms_min = commit ? sh_min.ms : '0;
  assign bus.ld_ls_min = commit ? sh_min.ls : '0;
  assign bus.ld_ms_sec = commit ? sh_sec.ms : '0;
  assign bus.ld_ls_sec = commit ? sh_sec.ls : '0;

endmodule
